// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver block-counter family: the sequencer
// state encoding and the standard LTE block-length constants.
package interleaver_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int K_SMALL         = 1056;
   localparam int K_LARGE         = 6144;
   localparam int DEFAULT_WIDTH   = 13;
   localparam int DEFAULT_MAX_LEN = 6144;

endpackage : interleaver_pkg

// File: rtl/block_count_core.sv
// Enable-gated position counter with synchronous clear and compare-to-target.
// On an enabled edge at the target it either wraps to zero (wrap=1) or holds.
module block_count_core
   import interleaver_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             wrap,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] count,
   output logic             at_target
);

   logic [WIDTH-1:0] count_q;

   assign at_target = (count_q == target);
   assign count     = count_q;

   // Position register: clear has priority over advance so an abort on the
   // final edge leaves the counter at zero.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         if (!at_target) begin
            count_q <= count_q + 1'b1;
         end else if (wrap) begin
            count_q <= '0;
         end
      end
   end

endmodule : block_count_core

// File: rtl/block_count_seq.sv
// Block-length-programmable interleaver position sequencer with start/done
// handshake, one-shot/continuous modes, abort and a completed-block counter.
// Optional build macro BLOCK_COUNT_SEQ_LEN_CHECK_EN rejects starts with
// block_len of 0 or above MAX_LEN and pulses len_err instead.
module block_count_seq
   import interleaver_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MAX_LEN = DEFAULT_MAX_LEN,
   parameter int FRAME_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   block_len,
   input  logic               continuous,
   input  logic               count_enable,
   input  logic               abort,
   output logic [WIDTH-1:0]   count,
   output logic [WIDTH-1:0]   target,
   output logic               target_reached,
   output logic               busy,
   output logic               done,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               len_err
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   target_q;
   logic               mode_q;
   logic [FRAME_W-1:0] frame_q;
   logic               done_q;
   logic               at_target;
   logic               len_ok;
   logic               idle_like;
   logic               accept;
   logic               final_edge;

`ifdef BLOCK_COUNT_SEQ_LEN_CHECK_EN
   logic len_err_q;

   assign len_ok  = (block_len != '0) && (32'(block_len) <= 32'(MAX_LEN));
   assign len_err = len_err_q;

   // Rejected-start pulse; any other cycle (including a legal start) clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= start && idle_like && !len_ok && !abort;
      end
   end
`else
   // Without the check every length is accepted and 0 encodes 2^WIDTH.
   logic unused_max_len;

   assign len_ok         = 1'b1;
   assign len_err        = 1'b0;
   assign unused_max_len = ^32'(MAX_LEN);
`endif

   // start is honoured from IDLE and DONE only; abort always wins.
   assign idle_like  = (state_q != COUNT);
   assign accept     = start && idle_like && len_ok && !abort;
   assign final_edge = (state_q == COUNT) && count_enable && at_target && !abort;

   block_count_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .clr       (abort || accept),
      .en        ((state_q == COUNT) && count_enable),
      .wrap      (mode_q),
      .target    (target_q),
      .count     (count),
      .at_target (at_target)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: abort, then accepted start, then one-shot completion.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned
      // (which would infer a latch).
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else if (accept) begin
         state_d = COUNT;
      end else if (final_edge && !mode_q) begin
         state_d = DONE;
      end
   end

   // Block parameters latched on start, completed-block counter and done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         target_q <= '0;
         mode_q   <= 1'b0;
         frame_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= final_edge;
         if (accept) begin
            target_q <= block_len - 1'b1;
            mode_q   <= continuous;
            frame_q  <= '0;
         end else if (final_edge) begin
            frame_q <= frame_q + 1'b1;
         end
      end
   end

   assign target         = target_q;
   assign frame_cnt      = frame_q;
   assign done           = done_q;
   assign busy           = (state_q == COUNT);
   assign target_reached = ((state_q == COUNT) || (state_q == DONE)) && at_target;

endmodule : block_count_seq

// File: doc/block_count_seq.md
Name: block_count_seq

Overview:
- Parametrised successor of the fixed two-size interleaver block counter.
- Counts interleaver input/output positions 0..K-1 for a block length K programmed per block at run time, instead of a hard 1056/6144 select.
- Adds a start/done handshake, a one-shot or continuous (back-to-back block) mode, abort, and a frame counter.
- Sits between the interleaver control FSM and the address generator/memory: count is the linear position, target_reached marks the last position.

Parameters:
- WIDTH, 13, width of count, block_len and target; maximum representable K is 2^WIDTH.
- MAX_LEN, 6144, largest legal K; used only when LEN_CHECK_EN is defined.
- FRAME_W, 8, width of frame_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a block; block_len and continuous are sampled on this cycle.
- block_len  in  WIDTH  block length K (number of positions).
- continuous  in  1  0 = one-shot, 1 = restart automatically after each block.
- count_enable  in  1  advance strobe; the counter holds when low.
- abort  in  1  synchronous return to IDLE.
- count  out  WIDTH  current position.
- target  out  WIDTH  latched K-1.
- target_reached  out  1  count == target while in COUNT or DONE.
- busy  out  1  high in COUNT.
- done  out  1  one-cycle pulse per completed block.
- frame_cnt  out  FRAME_W  number of blocks completed since the last start.
- len_err  out  1  one-cycle pulse when a start is rejected; tied 0 without LEN_CHECK_EN.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; count, target, frame_cnt, done, len_err all 0; busy=0; target_reached=0.
- States are IDLE, COUNT and DONE.
- IDLE:
  - count=0.
  - On start (accepted), latch target=block_len-1 (WIDTH-bit wrap) and mode=continuous; clear count and frame_cnt; go to COUNT on the next edge.
- COUNT:
  - count_enable=0: hold.
  - count_enable=1 and count!=target: count+1.
  - count_enable=1 and count==target (final edge):
    - Register a done pulse so it is high during the cycle after the final edge.
    - frame_cnt+1, wrapping modulo 2^FRAME_W.
    - Continuous mode: count wraps to 0 and the state stays COUNT.
    - One-shot mode: go to DONE; count holds target.
  - start is ignored while in COUNT.
- DONE:
  - count holds target; target_reached=1.
  - start behaves exactly as it does in IDLE (restart).
- target_reached is combinational from the state, count and target registers; no latency relative to count.
- Latency: start on cycle n gives busy=1 at n+1. With count_enable held high, K=N gives done at cycle n+N+1.
- Block length boundaries:
  - block_len=1: target=0; target_reached is high on entry to COUNT, and the first enabled edge completes the block.
  - block_len=0: target=all ones, i.e. K=2^WIDTH.
- abort: in any state, go to IDLE and set count=0 on the next edge; no done pulse; frame_cnt holds.
  - abort and start in the same cycle: abort wins.
  - abort on the final edge: abort wins; no done and no frame_cnt increment.
- reset asserted mid-block: immediate asynchronous clear; no done.

Optional Feature:
- Macro: BLOCK_COUNT_SEQ_LEN_CHECK_EN.
- Defined:
  - start with block_len==0 or block_len>MAX_LEN is rejected: len_err pulses on the next cycle; the state, target and count are unchanged.
  - A legal start clears len_err.
- Undefined:
  - No check is performed; len_err is constant 0; block_len=0 means 2^WIDTH.

Decomposition:
- Shared package interleaver_pkg holds:
  - the state enumeration typedef (IDLE/COUNT/DONE);
  - constants K_SMALL=1056, K_LARGE=6144, DEFAULT_WIDTH=13, DEFAULT_MAX_LEN=6144.
- One natural sub-module, block_count_core: the enable-gated WIDTH-bit counter with synchronous clear and compare-to-target. block_count_seq wraps it with the FSM, frame counter and handshake logic.

Test Plan:
- One-shot K=1056, count_enable held high:
  - busy for 1056 cycles; count 0..1055.
  - target_reached only at count=1055.
  - Single done pulse; count holds 1055 in DONE; frame_cnt=1.
- One-shot K=6144 with count_enable toggling 1,0 (half rate):
  - done arrives after 12288 COUNT cycles; count never exceeds 6143.
- Continuous K=40 for 3 blocks:
  - done pulses 40 cycles apart; count wraps 39->0 without a gap cycle.
  - frame_cnt reads 1, 2, 3.
  - start issued mid-block is ignored.
- Abort:
  - K=1056, abort at count=500: state returns to IDLE, count=0, no done.
  - abort together with start: the block does not start.
  - reset low at count=700: count=0 immediately (asynchronous).
- K=1:
  - target_reached=1 on entry to COUNT; done one cycle after the first enabled edge.
  - K=0 without the macro: target=8191.
- With BLOCK_COUNT_SEQ_LEN_CHECK_EN:
  - block_len=0 and block_len=6145 each give a len_err pulse and stay IDLE.
  - block_len=6144 is accepted with target=6143.
